// File: rtl/systola_feeder.sv
// Skewing input feeder for a ROWS x COLS systolic array: lane k of each accepted beat reaches the array edge 1+k cycles later.
// Optional macro SYSTOLA_FEEDER_PERF_EN adds a 16-bit saturating stall_cnt output counting STREAM bubble cycles.
module systola_feeder #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [KW-1:0]        cfg_k,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*COLS-1:0]    in_wvec,
  input  logic [8*ROWS-1:0]    in_avec,
  output logic [7:0]           out_w [0:COLS-1],
  output logic [7:0]           out_a [0:ROWS-1],
  output logic                 fire,
  output logic                 busy,
  output logic                 done
`ifdef SYSTOLA_FEEDER_PERF_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  localparam int MAXD      = (ROWS > COLS) ? ROWS : COLS;
  localparam int DRAIN_LEN = MAXD - 1;
  localparam int DCW       = (MAXD > 1) ? $clog2(MAXD) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   kLen_q, kLen_d;
  logic [KW-1:0]   beatCnt_q, beatCnt_d;
  logic [DCW-1:0]  drainCnt_q, drainCnt_d;
  logic            done_q, done_d;
  logic            fire_q;
  logic            accept;
  logic            lastBeat;

  assign accept   = in_valid && (state_q == STREAM);
  assign lastBeat = accept && (beatCnt_q == kLen_q - KW'(1));

  // Outputs are forced low while reset is asserted, not just after the edge.
  assign in_ready = rstn && (state_q == STREAM);
  assign busy     = rstn && (state_q != IDLE);
  assign done     = rstn && done_q;
  assign fire     = rstn && fire_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      kLen_q     <= '0;
      beatCnt_q  <= '0;
      drainCnt_q <= '0;
      done_q     <= 1'b0;
      fire_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      kLen_q     <= kLen_d;
      beatCnt_q  <= beatCnt_d;
      drainCnt_q <= drainCnt_d;
      done_q     <= done_d;
      fire_q     <= accept;
    end
  end

  always_comb begin
    state_d    = state_q;
    kLen_d     = kLen_q;
    beatCnt_d  = beatCnt_q;
    drainCnt_d = drainCnt_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_k != '0) begin
            kLen_d    = cfg_k;
            beatCnt_d = '0;
            state_d   = STREAM;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          beatCnt_d = beatCnt_q + KW'(1);
        end
        if (lastBeat) begin
          drainCnt_d = '0;
          // A 1x1 array has nothing left in flight, so the tile ends immediately.
          if (DRAIN_LEN == 0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drainCnt_q == DCW'(DRAIN_LEN - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drainCnt_d = drainCnt_q + DCW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Weight skew: lane j is a (j+1)-deep shift register; bubbles, drain and idle inject zeros.
  for (genvar j = 0; j < COLS; j++) begin : gWLane
    logic [7:0] sr_q [0:j];
    logic [7:0] laneIn_d;

    assign laneIn_d = accept ? in_wvec[8*j +: 8] : 8'h00;

    always_ff @(posedge clk) begin
      if (!rstn) begin
        for (int s = 0; s <= j; s++) sr_q[s] <= 8'h00;
      end else begin
        sr_q[0] <= laneIn_d;
        for (int s = 1; s <= j; s++) sr_q[s] <= sr_q[s-1];
      end
    end

    assign out_w[j] = rstn ? sr_q[j] : 8'h00;
  end

  // Activation skew mirrors the weight skew along the array's left edge.
  for (genvar i = 0; i < ROWS; i++) begin : gALane
    logic [7:0] sr_q [0:i];
    logic [7:0] laneIn_d;

    assign laneIn_d = accept ? in_avec[8*i +: 8] : 8'h00;

    always_ff @(posedge clk) begin
      if (!rstn) begin
        for (int s = 0; s <= i; s++) sr_q[s] <= 8'h00;
      end else begin
        sr_q[0] <= laneIn_d;
        for (int s = 1; s <= i; s++) sr_q[s] <= sr_q[s-1];
      end
    end

    assign out_a[i] = rstn ? sr_q[i] : 8'h00;
  end

`ifdef SYSTOLA_FEEDER_PERF_EN
  logic [15:0] stallCnt_q, stallCnt_d;

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (state_q == IDLE && start) begin
      stallCnt_d = 16'h0000;
    end else if (state_q == STREAM && !accept && stallCnt_q != 16'hFFFF) begin
      stallCnt_d = stallCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stallCnt_q <= 16'h0000;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_systola_feeder.sv
// Directed self-checking bench for systola_feeder (default 4x4, KW=8).
// Inputs change on the falling edge; outputs of that cycle are checked 1 time unit later.
module tb_systola_feeder;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KW   = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [7:0]  cfgK;
  logic        inValid;
  logic        inReady;
  logic [31:0] inW;
  logic [31:0] inA;
  logic [7:0]  outW [0:COLS-1];
  logic [7:0]  outA [0:ROWS-1];
  logic        fire;
  logic        busy;
  logic        done;
`ifdef SYSTOLA_FEEDER_PERF_EN
  logic [15:0] stallCnt;
`endif

  always #5 clk = ~clk;

  systola_feeder #(.ROWS(ROWS), .COLS(COLS), .KW(KW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .cfg_k    (cfgK),
    .in_valid (inValid),
    .in_ready (inReady),
    .in_wvec  (inW),
    .in_avec  (inA),
    .out_w    (outW),
    .out_a    (outA),
    .fire     (fire),
    .busy     (busy),
    .done     (done)
`ifdef SYSTOLA_FEEDER_PERF_EN
    ,
    .stall_cnt(stallCnt)
`endif
  );

  typedef struct packed {
    logic        start;
    logic [7:0]  k;
    logic        valid;
    logic [31:0] w;
    logic [31:0] a;
    logic        eRdy;
    logic        eBusy;
    logic        eFire;
    logic        eDone;
    logic [7:0]  eOw0;
    logic [7:0]  eOw1;
    logic [7:0]  eOw3;
    logic [7:0]  eOa0;
    logic [7:0]  eOa3;
  } vec_t;

  vec_t tbl [9];
  int nChecks = 0;
  int nFail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [7:0] k, input logic v,
                               input logic [31:0] w, input logic [31:0] a);
    @(negedge clk);
    rstn    = r;
    start   = s;
    cfgK    = k;
    inValid = v;
    inW     = w;
    inA     = a;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int beats;
    int waitCycles;

    // 3-beat tile, lane0 listed last in each word: lane0 = byte 0.
    tbl[0] = '{1'b1, 8'd3, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1] = '{1'b0, 8'd0, 1'b1, 32'h01020304, 32'h11121314, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2] = '{1'b0, 8'd0, 1'b1, 32'h21222324, 32'h31323334, 1'b1, 1'b1, 1'b1, 1'b0, 8'h04, 8'h00, 8'h00, 8'h14, 8'h00};
    tbl[3] = '{1'b0, 8'd0, 1'b1, 32'h41424344, 32'h51525354, 1'b1, 1'b1, 1'b1, 1'b0, 8'h24, 8'h03, 8'h00, 8'h34, 8'h00};
    tbl[4] = '{1'b0, 8'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'h44, 8'h23, 8'h00, 8'h54, 8'h00};
    tbl[5] = '{1'b1, 8'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h43, 8'h01, 8'h00, 8'h11};
    tbl[6] = '{1'b0, 8'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h21, 8'h00, 8'h31};
    tbl[7] = '{1'b0, 8'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h41, 8'h00, 8'h51};
    tbl[8] = '{1'b0, 8'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    rstn = 1'b0; start = 1'b0; cfgK = 8'd0; inValid = 1'b0; inW = 32'h0; inA = 32'h0;

    // Reset state, with a beat offered during reset.
    applyStimulus(1'b0, 1'b1, 8'd3, 1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A);
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A);
    checkOutput("rst ready", inReady, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst fire", fire, 0);
    checkOutput("rst done", done, 0);
    checkOutput("rst outW0", outW[0], 0);
    checkOutput("rst outA0", outA[0], 0);
    idleCycle();
    checkOutput("post-rst busy", busy, 0);
    checkOutput("post-rst outW0", outW[0], 0);

    // Table: 3-beat tile with skew, drain length, start ignored in DRAIN.
    for (int r = 0; r < 9; r++) begin
      applyStimulus(1'b1, tbl[r].start, tbl[r].k, tbl[r].valid, tbl[r].w, tbl[r].a);
      checkOutput($sformatf("tbl%0d ready", r), inReady, tbl[r].eRdy);
      checkOutput($sformatf("tbl%0d busy", r),  busy,    tbl[r].eBusy);
      checkOutput($sformatf("tbl%0d fire", r),  fire,    tbl[r].eFire);
      checkOutput($sformatf("tbl%0d done", r),  done,    tbl[r].eDone);
      checkOutput($sformatf("tbl%0d outW0", r), outW[0], tbl[r].eOw0);
      checkOutput($sformatf("tbl%0d outW1", r), outW[1], tbl[r].eOw1);
      checkOutput($sformatf("tbl%0d outW3", r), outW[3], tbl[r].eOw3);
      checkOutput($sformatf("tbl%0d outA0", r), outA[0], tbl[r].eOa0);
      checkOutput($sformatf("tbl%0d outA3", r), outA[3], tbl[r].eOa3);
    end

    // Bubble between two beats of a 2-beat tile.
    applyStimulus(1'b1, 1'b1, 8'd2, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 32'h000000AA, 32'h000000CC);
    checkOutput("bub ready c0", inReady, 1);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checkOutput("bub fire c1", fire, 1);
    checkOutput("bub outW0 c1", outW[0], 8'hAA);
    checkOutput("bub outA0 c1", outA[0], 8'hCC);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 32'h000000BB, 32'h000000DD);
    checkOutput("bub fire c2", fire, 0);
    checkOutput("bub outW0 c2", outW[0], 8'h00);
    checkOutput("bub outA0 c2", outA[0], 8'h00);
    checkOutput("bub ready c2", inReady, 1);
    idleCycle();
    checkOutput("bub fire c3", fire, 1);
    checkOutput("bub outW0 c3", outW[0], 8'hBB);
    checkOutput("bub outA0 c3", outA[0], 8'hDD);
    checkOutput("bub ready c3", inReady, 0);
`ifdef SYSTOLA_FEEDER_PERF_EN
    checkOutput("bub stallCnt", stallCnt, 1);
`endif
    idleCycle();
    idleCycle();
    checkOutput("bub busy c5", busy, 1);
    checkOutput("bub done c5", done, 0);
    idleCycle();
    checkOutput("bub done c6", done, 1);
    checkOutput("bub busy c6", busy, 0);

    // Zero-length tile.
    applyStimulus(1'b1, 1'b1, 8'd0, 1'b1, 32'h12345678, 32'h12345678);
    checkOutput("k0 busy c0", busy, 0);
    idleCycle();
    checkOutput("k0 done c1", done, 1);
    checkOutput("k0 busy c1", busy, 0);
    checkOutput("k0 fire c1", fire, 0);
    checkOutput("k0 ready c1", inReady, 0);
    idleCycle();
    checkOutput("k0 done c2", done, 0);
    checkOutput("k0 fire c2", fire, 0);

    // Back-to-back tiles with start held; cfg_k change after latch has no effect.
    applyStimulus(1'b1, 1'b1, 8'd1, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 8'd1, 1'b1, 32'h00000011, 32'h00000022);
    checkOutput("b2b ready c0", inReady, 1);
    applyStimulus(1'b1, 1'b1, 8'd1, 1'b0, 32'h0, 32'h0);
    checkOutput("b2b ready c1", inReady, 0);
    checkOutput("b2b fire c1", fire, 1);
    checkOutput("b2b outW0 c1", outW[0], 8'h11);
    applyStimulus(1'b1, 1'b1, 8'd1, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 8'd1, 1'b0, 32'h0, 32'h0);
    checkOutput("b2b busy c3", busy, 1);
    applyStimulus(1'b1, 1'b1, 8'd1, 1'b0, 32'h0, 32'h0);
    checkOutput("b2b done c4", done, 1);
    checkOutput("b2b busy c4", busy, 0);
    applyStimulus(1'b1, 1'b0, 8'd7, 1'b1, 32'h00000033, 32'h00000044);
    checkOutput("b2b ready c5", inReady, 1);
    checkOutput("b2b busy c5", busy, 1);
    checkOutput("b2b done c5", done, 0);
    applyStimulus(1'b1, 1'b0, 8'd7, 1'b1, 32'h00000055, 32'h00000066);
    checkOutput("b2b ready c6", inReady, 0);
    checkOutput("b2b outW0 c6", outW[0], 8'h33);
    idleCycle();
    checkOutput("b2b fire c7", fire, 0);
    checkOutput("b2b outW0 c7", outW[0], 8'h00);
    idleCycle();
    idleCycle();
    checkOutput("b2b done c9", done, 1);

    // Reset during beat 2 of a 4-beat tile.
    applyStimulus(1'b1, 1'b1, 8'd4, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 32'h0A0B0C0D, 32'h1A1B1C1D);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 32'h2A2B2C2D, 32'h3A3B3C3D);
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, 32'h5A5A5A5A, 32'h5A5A5A5A);
    checkOutput("midrst ready during", inReady, 0);
    checkOutput("midrst busy during", busy, 0);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 32'h6B6B6B6B, 32'h6B6B6B6B);
    checkOutput("midrst ready", inReady, 0);
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst fire", fire, 0);
    checkOutput("midrst done", done, 0);
    checkOutput("midrst outW0", outW[0], 8'h00);
    checkOutput("midrst outW1", outW[1], 8'h00);
    checkOutput("midrst outA0", outA[0], 8'h00);
    idleCycle();
    checkOutput("midrst outW3 +1", outW[3], 8'h00);
    checkOutput("midrst outA3 +1", outA[3], 8'h00);
    checkOutput("midrst done +1", done, 0);

    // Maximum tile length: exactly 255 beats accepted, then a 3-cycle drain.
    applyStimulus(1'b1, 1'b1, 8'd255, 1'b0, 32'h0, 32'h0);
    beats = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, i, i);
      if (!inReady) break;
      beats++;
    end
    checkOutput("max beats", beats, 255);
    checkOutput("max busy drain", busy, 1);
    waitCycles = 0;
    for (int i = 0; i < 10; i++) begin
      idleCycle();
      waitCycles++;
      if (done) break;
    end
    checkOutput("max done delay", waitCycles, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/systola_feeder.md
SYSTOLA_FEEDER -- requirements
Module: systola_feeder

Interface
REQ-001 SHALL provide parameter ROWS, default 4, number of array rows (activation lanes).
REQ-002 SHALL provide parameter COLS, default 4, number of array columns (weight lanes).
REQ-003 SHALL provide parameter KW, default 8, width of the tile-length field.
REQ-004 SHALL provide ports:
  - clk  in  1  sole clock, rising edge.
  - rstn  in  1  reset, synchronous, active-low.
  - start  in  1  begin tile; sampled only in IDLE.
  - cfg_k  in  KW  beats per tile; latched on accepted start.
  - in_valid  in  1  input beat valid.
  - in_ready  out  1  feeder accepts beat.
  - in_wvec  in  8*COLS  weight vector; lane j = bits [8j+7:8j].
  - in_avec  in  8*ROWS  activation vector; lane i = bits [8i+7:8i].
  - out_w  out  8 x [0:COLS-1]  skewed weights to array top edge.
  - out_a  out  8 x [0:ROWS-1]  skewed activations to array left edge.
  - fire  out  1  to top-left PE; high when lane 0 carries a real beat.
  - busy  out  1  high in STREAM or DRAIN.
  - done  out  1  one-cycle tile-complete pulse.

Function
REQ-005 SHALL implement FSM IDLE -> STREAM -> DRAIN -> IDLE.
REQ-006 IDLE: start=1 with cfg_k!=0 SHALL latch cfg_k, clear beat counter, go to STREAM.
REQ-007 IDLE: start=1 with cfg_k==0 SHALL pulse done next cycle and stay in IDLE.
REQ-008 in_ready SHALL equal 1 only in STREAM; beat accepted when in_valid && in_ready.
REQ-009 Accepted beat: lane 0 of both vectors SHALL appear on out_w[0]/out_a[0] one cycle later; lane k SHALL appear 1+k cycles after acceptance (per-lane shift depth k).
REQ-010 fire SHALL be 1 exactly in the cycle lane-0 data of an accepted beat is on out_w[0]/out_a[0]; else 0.
REQ-011 STREAM cycle with no accepted beat (bubble) SHALL inject 0x00 into every lane-0 input; skew registers SHALL still shift; fire SHALL be 0 in the matching output cycle.
REQ-012 STREAM SHALL go to DRAIN in the cycle after the cfg_k-th beat is accepted.
REQ-013 DRAIN SHALL last exactly max(ROWS,COLS)-1 cycles, shifting in zeros with fire=0.
REQ-014 DRAIN exit SHALL pulse done for one cycle concurrent with return to IDLE; busy SHALL be 0 in that cycle.
REQ-015 start during STREAM/DRAIN SHALL be ignored; cfg_k changes after latch SHALL have no effect.
REQ-016 IDLE SHALL shift zeros through skew registers, so outputs return to 0 once flushed.
REQ-017 Beat counter SHALL be KW bits, never wrap: cfg_k = 2^KW-1 is the max tile.
REQ-018 Back-to-back tiles: start asserted in the done cycle SHALL be accepted, STREAM entered next cycle.

Reset
REQ-019 rstn=0 at a clock edge SHALL force IDLE, clear all skew registers and counters, from any state including mid-tile.
REQ-020 During and after reset: out_w, out_a, fire, busy, done, in_ready SHALL be 0.
REQ-021 A beat presented in the reset cycle SHALL NOT be accepted or appear on outputs.

Configuration
REQ-022 Macro SYSTOLA_FEEDER_PERF_EN defined: SHALL add output stall_cnt (16 bits), counting STREAM bubble cycles; cleared on reset and on accepted start; saturates at 0xFFFF.
REQ-023 Macro undefined: stall_cnt port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-024 Reset mid-STREAM (beat 2 of 4) -> next cycle IDLE, all outputs 0, in_ready 0.
REQ-025 ROWS=COLS=4, cfg_k=3, beats w=a={0x04,0x03,0x02,0x01} per beat, no bubbles -> out_w[3]/out_a[3]=0x01 at cycles 4,5,6 after first accept; fire high cycles 1-3; done pulse 3 DRAIN cycles after STREAM exit.
REQ-026 cfg_k=2, in_valid low one cycle between beats -> fire pattern 1,0,1; zero lane values in bubble slot; stall_cnt=1 with PERF_EN.
REQ-027 start with cfg_k=0 -> done=1 next cycle, busy never 1, fire never 1.
REQ-028 start held high through done -> second tile begins the cycle after done with no idle gap; start during STREAM ignored.
